// File: rtl/execution_operand_stage.sv
`timescale 1ns/1ps
// EX-stage operand resolution: EX/MEM and MEM/WB forwarding, operand-B immediate modes,
// and a one-entry valid/ready output slot with flush and a saturating forwarding counter.
module execution_operand_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic [15:0]       imm,
    input  logic [1:0]        src_b_sel,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [WIDTH-1:0]  exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [WIDTH-1:0]  memwb_result,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_store,
    output logic [1:0]        out_fwd_a,
    output logic [1:0]        out_fwd_b,
    output logic [CNT_W-1:0]  fwd_count
);

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       code_rs;
    logic [1:0]       code_rt;
    logic             accept;
    logic [1:0]       cnt_inc;
    logic [CNT_W:0]   cnt_sum;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
    always_comb begin
        fwd_rs  = rs_data;
        code_rs = 2'd0;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
            fwd_rs  = exmem_result;
            code_rs = 2'd1;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
            fwd_rs  = memwb_result;
            code_rs = 2'd2;
        end
    end

    always_comb begin
        fwd_rt  = rt_data;
        code_rt = 2'd0;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_addr)) begin
            fwd_rt  = exmem_result;
            code_rt = 2'd1;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_addr)) begin
            fwd_rt  = memwb_result;
            code_rt = 2'd2;
        end
    end

    always_comb begin
        case (src_b_sel)
            2'd0:    op_b = fwd_rt;
            2'd1:    op_b = {{(WIDTH-16){imm[15]}}, imm};
            2'd2:    op_b = {{(WIDTH-16){1'b0}}, imm};
            default: op_b = {{(WIDTH-5){1'b0}}, imm[10:6]};
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Operand B only counts as forwarded when rt actually feeds the ALU.
    always_comb begin
        cnt_inc = {1'b0, code_rs != 2'd0}
                + {1'b0, (src_b_sel == 2'd0) && (code_rt != 2'd0)};
        cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, cnt_inc};
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        store_d = store_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            a_d     = fwd_rs;
            b_d     = op_b;
            store_d = fwd_rt;
            fwd_a_d = code_rs;
            fwd_b_d = code_rt;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            store_q <= '0;
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            store_q <= store_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_store = store_q;
    assign out_fwd_a = fwd_a_q;
    assign out_fwd_b = fwd_b_q;
    assign fwd_count = cnt_q;

endmodule

// File: tb/tb_execution_operand_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for execution_operand_stage: the driver pushes reference results on accept,
// an independent negedge monitor compares whatever the slot presents.
module tb_execution_operand_stage;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNT_MAX = 15;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] rs_addr, rt_addr;
    logic [WIDTH-1:0]  rs_data, rt_data;
    logic [15:0]       imm;
    logic [1:0]        src_b_sel;
    logic              exmem_regwrite;
    logic [REG_AW-1:0] exmem_rd;
    logic [WIDTH-1:0]  exmem_result;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [WIDTH-1:0]  memwb_result;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_a, out_b, out_store;
    logic [1:0]        out_fwd_a, out_fwd_b;
    logic [CNT_W-1:0]  fwd_count;

    execution_operand_stage #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .imm            (imm),
        .src_b_sel      (src_b_sel),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_store      (out_store),
        .out_fwd_a      (out_fwd_a),
        .out_fwd_b      (out_fwd_b),
        .fwd_count      (fwd_count)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   model_cnt;
    int   n_cmp;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference resolution: youngest matching producer wins, register 0 is hardwired.
    function automatic void resolve(input logic [4:0] addr, input logic [31:0] rf,
                                    output logic [31:0] val, output logic [1:0] code);
        val  = rf;
        code = 2'd0;
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == addr) begin
            val  = exmem_result;
            code = 2'd1;
        end else if (memwb_regwrite && memwb_rd != 0 && memwb_rd == addr) begin
            val  = memwb_result;
            code = 2'd2;
        end
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] rt_v;
        int          n;
        resolve(rs_addr, rs_data, e.a, e.fa);
        resolve(rt_addr, rt_data, rt_v, e.fb);
        e.st = rt_v;
        case (src_b_sel)
            2'd0:    e.b = rt_v;
            2'd1:    e.b = 32'(int'($signed(imm)));
            2'd2:    e.b = 32'(imm);
            default: e.b = 32'((imm >> 6) & 16'd31);
        endcase
        n = (e.fa != 0 ? 1 : 0) + ((src_b_sel == 0 && e.fb != 0) ? 1 : 0);
        model_cnt = (model_cnt + n > CNT_MAX) ? CNT_MAX : model_cnt + n;
        e.cnt = 4'(model_cnt);
        return e;
    endfunction

    // Called with inputs already applied for this cycle; returns just after the next edge.
    task automatic step();
        logic exp_valid, exp_ready;
        #1;
        exp_valid = (exp_q.size() > 0);
        exp_ready = !exp_valid || out_ready;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("fwd_count", 64'(fwd_count), 64'(model_cnt));
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            last      = '0;
        end else if (in_valid && exp_ready && !flush) begin
            exp_q.push_back(predict());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                          input logic [31:0] rtd, input logic [15:0] im, input logic [1:0] sel);
        rs_addr   = rs;
        rs_data   = rsd;
        rt_addr   = rt;
        rt_data   = rtd;
        imm       = im;
        src_b_sel = sel;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_a"}, 64'(out_a), 64'd0);
        check({tag, "_b"}, 64'(out_b), 64'd0);
        check({tag, "_store"}, 64'(out_store), 64'd0);
        check({tag, "_fwd"}, 64'({out_fwd_a, out_fwd_b}), 64'd0);
        check({tag, "_cnt"}, 64'(fwd_count), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Monitor: the presented item must match the oldest expected entry every cycle it is held.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("sb_a", 64'(out_a), 64'(exp_q[0].a));
                    check("sb_b", 64'(out_b), 64'(exp_q[0].b));
                    check("sb_store", 64'(out_store), 64'(exp_q[0].st));
                    check("sb_fwd_a", 64'(out_fwd_a), 64'(exp_q[0].fa));
                    check("sb_fwd_b", 64'(out_fwd_b), 64'(exp_q[0].fb));
                    check("sb_cnt", 64'(fwd_count), 64'(exp_q[0].cnt));
                    if (out_ready || flush) begin
                        last = exp_q.pop_front();
                    end
                end
            end else begin
                check("idle_hold_a", 64'(out_a), 64'(last.a));
                check("idle_hold_b", 64'(out_b), 64'(last.b));
                check("idle_hold_store", 64'(out_store), 64'(last.st));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_cnt = 0;
        last = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        exmem_regwrite = 1'b0;
        exmem_rd = '0;
        exmem_result = '0;
        memwb_regwrite = 1'b0;
        memwb_rd = '0;
        memwb_result = '0;
        set_op(5'd0, 32'd0, 5'd0, 32'd0, 16'd0, 2'd0);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // No hazards
        set_op(5'd3, 32'h11, 5'd4, 32'h22, 16'd0, 2'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        check("nohaz_a", 64'(out_a), 64'h11);
        check("nohaz_b", 64'(out_b), 64'h22);

        // Forward priority, then register 0 never forwards
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBBBB;
        set_op(5'd5, 32'h5555, 5'd4, 32'h22, 16'd0, 2'd0);
        step();
        check("prio_a", 64'(out_a), 64'hAAAA);
        check("prio_fwd_a", 64'(out_fwd_a), 64'd1);
        exmem_rd = 5'd0;
        memwb_rd = 5'd0;
        set_op(5'd0, 32'h1234, 5'd0, 32'h99, 16'd0, 2'd0);
        step();
        check("r0_a", 64'(out_a), 64'h1234);
        check("r0_fwd_a", 64'(out_fwd_a), 64'd0);

        // Immediate modes
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            set_op(5'd6, 32'h66, 5'd7, 32'h77, 16'h8143, 2'(s));
            step();
            check("imm_store", 64'(out_store), 64'h77);
        end
        check("imm_shamt", 64'(out_b), 64'h5);

        // Stall: operands held while the forwarding bus churns
        exmem_regwrite = 1'b1; exmem_rd = 5'd9; exmem_result = 32'hC0DE;
        set_op(5'd9, 32'h1, 5'd9, 32'h2, 16'd0, 2'd0);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exmem_result = $urandom;
            step();
            check("stall_a", 64'(out_a), 64'hC0DE);
        end
        out_ready = 1'b1;
        step();

        // Flush overrides accept and consume; counter unchanged
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        step();

        // Reset during a hold
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_all_zero("rst_hold");
        rst = 1'b0;
        out_ready = 1'b1;

        // Counter saturation: 7 double-forwards to 14, then clamp at 15
        exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'hFACE;
        set_op(5'd7, 32'h0, 5'd7, 32'h0, 16'd0, 2'd0);
        in_valid = 1'b1;
        repeat (7) step();
        in_valid = 1'b0;
        step();
        check("sat_14", 64'(fwd_count), 64'd14);
        in_valid = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        step();
        check("sat_15", 64'(fwd_count), 64'd15);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst            = ($urandom_range(0, 49) == 0);
            flush          = ($urandom_range(0, 9) == 0);
            in_valid       = ($urandom_range(0, 9) < 7);
            out_ready      = ($urandom_range(0, 9) < 7);
            exmem_regwrite = $urandom_range(0, 1) == 1;
            exmem_rd       = 5'($urandom_range(0, 3));
            exmem_result   = $urandom;
            memwb_regwrite = $urandom_range(0, 1) == 1;
            memwb_rd       = 5'($urandom_range(0, 3));
            memwb_result   = $urandom;
            set_op(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                   16'($urandom), 2'($urandom_range(0, 3)));
            step();
        end

        // Drain
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
